// File: rtl/uart_receiver.sv
// Purpose: 16x-oversampled UART receiver (1 start, DATA_BITS data LSB first, 1 stop) into a single holding register.
// Latency: rxd is 2-flop synchronized; data/data_valid/frame_err/overrun update on the edge that samples the stop bit.
// Backpressure: one-deep valid/ack holding register; a byte completing while unacknowledged overwrites it and pulses overrun.
//
// Ports:
//   sys_clk, rst             - system clock, asynchronous active-high reset
//   rx_clk_en                - one-cycle tick at 16x baud
//   rxd                      - asynchronous serial input, idle high
//   data, data_valid         - last received byte and its pending flag
//   data_ack                 - consumer takes the byte
//   frame_err, overrun       - one-cycle error pulses
module uart_receiver #(
    parameter int DATA_BITS = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 rx_clk_en,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t               state, state_nxt;
    logic                 rxd_m, rxd_s;
    logic [3:0]           tick_cnt, tick_cnt_nxt;
    logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 data_valid_nxt, frame_err_nxt, overrun_nxt;

    // Line synchronizer; resets to the idle (high) level so reset release never looks like a start bit.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            data       <= data_nxt;
            data_valid <= data_valid_nxt;
            frame_err  <= frame_err_nxt;
            overrun    <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        tick_cnt_nxt   = tick_cnt;
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        data_nxt       = data;
        // An ack retires the pending byte; a byte completing this cycle overrides below.
        data_valid_nxt = data_valid & ~data_ack;
        frame_err_nxt  = 1'b0;
        overrun_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                // Edge detection runs every cycle so the start is caught to within one sys_clk.
                if (!rxd_s) begin
                    state_nxt    = ST_START;
                    tick_cnt_nxt = '0;
                end
            end

            ST_START: begin
                if (rx_clk_en) begin
                    if (tick_cnt == 4'd7) begin
                        if (!rxd_s) begin
                            state_nxt    = ST_DATA;
                            tick_cnt_nxt = '0;
                            bit_cnt_nxt  = '0;
                        end else begin
                            // Line went back high before mid-bit: a glitch, not a frame.
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end

            ST_DATA: begin
                if (rx_clk_en) begin
                    if (tick_cnt == 4'd15) begin
                        // Right shift: the first (LSB) bit ends up in bit 0 after the last shift.
                        shreg_nxt    = {rxd_s, shreg[DATA_BITS-1:1]};
                        bit_cnt_nxt  = bit_cnt + 1'b1;
                        tick_cnt_nxt = '0;
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = ST_STOP;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end

            ST_STOP: begin
                if (rx_clk_en) begin
                    if (tick_cnt == 4'd15) begin
                        tick_cnt_nxt = '0;
                        if (rxd_s) begin
                            data_nxt       = shreg;
                            data_valid_nxt = 1'b1;
                            // Simultaneous ack frees the old byte, so that is not an overrun.
                            overrun_nxt    = data_valid & ~data_ack;
                            state_nxt      = ST_IDLE;
                        end else begin
                            frame_err_nxt = 1'b1;
                            state_nxt     = ST_WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end

            ST_WAIT_HIGH: begin
                // Absorb a break: no new frame until the line has returned to idle.
                if (rxd_s) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Purpose: directed self-checking bench for uart_receiver (reset, single byte, glitch, framing, overrun, ack collision).
// Latency: expected stop-sample cycle is derived from tick counting: 2-cycle sync, detect, then the 152nd tick.
// Backpressure: data_ack is driven by the bench, including on the exact completion cycle for the collision case.
module tb_uart_receiver;

    localparam int DB          = 8;
    localparam int CPB         = 64;               // sys_clk cycles per bit: 16 ticks x 4 cycles
    localparam int SAMPLE_TICK = 8 + 16 * (DB + 1); // tick that samples the stop bit

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_clk_en = 1'b0;
    logic          rxd = 1'b1;
    logic          data_ack = 1'b0;
    logic [DB-1:0] data;
    logic          data_valid;
    logic          frame_err;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int phase  = 0;

    logic          dv_before, dv_after, fe_after, fe_after2, ov_after;
    logic [DB-1:0] data_after;

    always #5 sys_clk = ~sys_clk;

    uart_receiver #(.DATA_BITS(DB)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .rx_clk_en  (rx_clk_en),
        .rxd        (rxd),
        .data       (data),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, tally error pulses, and drive the tick for the coming rising edge.
    task automatic step();
        @(negedge sys_clk);
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
        end
        rx_clk_en = (phase == 0);
        phase = (phase + 1) % 4;
    endtask

    // Drives one frame for ncyc cycles. Step k's rxd value reaches rxd_m at rising edge k, rxd_s at k+1,
    // START is entered at k=2, so ticks from k=3 on are counted; the SAMPLE_TICK-th one completes the frame.
    task automatic send_frame(input logic [DB-1:0] b, input logic stop, input logic ack_done, input int ncyc);
        int tcount;
        int done_k;
        int bi;
        tcount = 0;
        done_k = -1;
        for (int k = 0; k < ncyc; k++) begin
            bi = k / CPB;
            step();
            if (k >= 3 && rx_clk_en) tcount++;
            if (done_k < 0 && k >= 3 && rx_clk_en && tcount == SAMPLE_TICK) begin
                done_k    = k;
                dv_before = data_valid;
                data_ack  = ack_done;
            end else begin
                data_ack = 1'b0;
            end
            if (done_k >= 0 && k == done_k + 1) begin
                dv_after   = data_valid;
                data_after = data;
                fe_after   = frame_err;
                ov_after   = overrun;
            end
            if (done_k >= 0 && k == done_k + 2) fe_after2 = frame_err;
            if (bi == 0)       rxd = 1'b0;
            else if (bi <= DB) rxd = b[bi-1];
            else               rxd = stop;
        end
    endtask

    task automatic ack();
        step();
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (4) step();
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        repeat (20) step();

        // Reset mid-frame: 200 cycles reaches the DATA state, then reset and idle for 200 ticks
        send_frame(8'hC3, 1'b1, 1'b0, 200);
        rxd = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (800) step();
        chk("midrst_data", 32'(data), 32'h0);
        chk("midrst_valid", 32'(data_valid), 32'h0);
        chk("midrst_fe_cnt", 32'(fe_cnt), 32'd0);
        chk("midrst_ov_cnt", 32'(ov_cnt), 32'd0);

        // Single byte with precise valid timing
        send_frame(8'hA5, 1'b1, 1'b0, 10 * CPB);
        chk("a5_valid_before", 32'(dv_before), 32'h0);
        chk("a5_valid_after", 32'(dv_after), 32'h1);
        chk("a5_data_after", 32'(data_after), 32'hA5);
        repeat (100) step();
        chk("a5_valid_hold", 32'(data_valid), 32'h1);
        ack();
        chk("a5_valid_cleared", 32'(data_valid), 32'h0);
        ack();
        chk("idle_ack_valid", 32'(data_valid), 32'h0);
        chk("idle_ack_data", 32'(data), 32'hA5);

        // Glitch: low for 3 ticks only
        step();
        rxd = 1'b0;
        repeat (12) step();
        rxd = 1'b1;
        repeat (200) step();
        chk("glitch_valid", 32'(data_valid), 32'h0);
        chk("glitch_fe_cnt", 32'(fe_cnt), 32'd0);
        chk("glitch_ov_cnt", 32'(ov_cnt), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 10 * CPB);
        chk("3c_data", 32'(data), 32'h3C);
        chk("3c_valid", 32'(data_valid), 32'h1);
        ack();

        // Framing error followed by a 40-bit break
        send_frame(8'h7E, 1'b0, 1'b0, 10 * CPB);
        chk("fe_pulse", 32'(fe_after), 32'h1);
        chk("fe_pulse_width", 32'(fe_after2), 32'h0);
        chk("fe_valid", 32'(dv_after), 32'h0);
        chk("fe_data_kept", 32'(data_after), 32'h3C);
        repeat (40 * CPB) step();
        chk("break_fe_cnt", 32'(fe_cnt), 32'd1);
        chk("break_valid", 32'(data_valid), 32'h0);
        chk("break_ov_cnt", 32'(ov_cnt), 32'd0);
        rxd = 1'b1;
        repeat (100) step();
        send_frame(8'h55, 1'b1, 1'b0, 10 * CPB);
        chk("55_data", 32'(data), 32'h55);
        chk("55_valid", 32'(data_valid), 32'h1);
        ack();

        // Overrun: second byte lands on an unacknowledged first
        send_frame(8'h11, 1'b1, 1'b0, 10 * CPB);
        chk("11_overrun", 32'(ov_after), 32'h0);
        send_frame(8'h22, 1'b1, 1'b0, 10 * CPB);
        chk("22_overrun_pulse", 32'(ov_after), 32'h1);
        chk("22_data", 32'(data_after), 32'h22);
        chk("22_valid", 32'(dv_after), 32'h1);
        repeat (4) step();
        chk("ov_cnt", 32'(ov_cnt), 32'd1);
        ack();

        // Ack on the exact completion cycle of the second byte
        send_frame(8'h00, 1'b1, 1'b0, 10 * CPB);
        chk("00_data", 32'(data_after), 32'h00);
        send_frame(8'hFF, 1'b1, 1'b1, 10 * CPB);
        chk("coll_valid_before", 32'(dv_before), 32'h1);
        chk("coll_valid_after", 32'(dv_after), 32'h1);
        chk("coll_data", 32'(data_after), 32'hFF);
        chk("coll_overrun", 32'(ov_after), 32'h0);
        repeat (4) step();
        chk("coll_ov_cnt", 32'(ov_cnt), 32'd1);
        chk("final_fe_cnt", 32'(fe_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
